// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath
// Description : 32-bit bus-based CPU datapath. Sixteen general registers plus
//               HI/LO/PC/MDR/MAR/IR/Y/Z share one prioritised internal bus.
//               The ALU takes Y and the bus and produces a 64-bit result that
//               is captured into ZHI/ZLO.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        HIin,
    input  logic        Loin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        MARin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        ZHIin,
    input  logic        ZLOin,
    input  logic        HIout,
    input  logic        Loout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Yout,
    input  logic        Cout,
    input  logic        InPortout,
    input  logic        ZHIout,
    input  logic        ZHighSelect,
    input  logic        ZLOout,
    input  logic        ZLowSelect,
    input  logic        MDRread,
    input  logic        IncPC,
    input  logic [4:0]  ALUSelection,
    input  logic [31:0] Mdatain,
    output logic [31:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
    output logic [31:0] R8,  R9,  R10, R11, R12, R13, R14, R15,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Y,
    output logic [31:0] ZHI,
    output logic [31:0] ZLO,
    output logic [31:0] PC,
    output logic [31:0] MDR,
    output logic [31:0] MAR,
    output logic [31:0] IR,
    output logic [63:0] Z_register
);

    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_ROR  = 5'b00111;
    localparam logic [4:0] c_OP_ROL  = 5'b01000;
    localparam logic [4:0] c_OP_SHL  = 5'b01001;
    localparam logic [4:0] c_OP_SHRA = 5'b01010;
    localparam logic [4:0] c_OP_SHR  = 5'b01011;
    localparam logic [4:0] c_OP_MUL  = 5'b01100;
    localparam logic [4:0] c_OP_DIV  = 5'b01101;
    localparam logic [4:0] c_OP_NEG  = 5'b01110;
    localparam logic [4:0] c_OP_NOT  = 5'b01111;

    logic [15:0][31:0] r_gpr;
    logic [31:0]       r_hi, r_lo, r_pc, r_mdr, r_mar, r_ir, r_y, r_zhi, r_zlo;

    logic [15:0]       w_rin;
    logic [15:0]       w_rout;
    logic [31:0]       w_bus;
    logic [31:0]       w_c;
    logic [63:0]       w_alu;

    logic [4:0]        w_shamt;
    logic [31:0]       w_rotr;
    logic [31:0]       w_rotl;
    logic [63:0]       w_prod;
    logic [31:0]       w_quot;
    logic [31:0]       w_rem;

    assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Immediate field of IR, sign-extended from bit 18
    assign w_c = {{13{r_ir[18]}}, r_ir[18:0]};

    // Bus mux: lowest priority source assigned first, so later (higher) wins
    always_comb begin
        w_bus = 32'd0;
        if (Yout)                  w_bus = r_y;
        if (Cout)                  w_bus = w_c;
        if (InPortout)             w_bus = 32'd0;   // in-port reserved, reads zero
        if (MDRout)                w_bus = r_mdr;
        if (PCout)                 w_bus = r_pc;
        if (ZLOout || ZLowSelect)  w_bus = r_zlo;
        if (ZHIout || ZHighSelect) w_bus = r_zhi;
        if (Loout)                 w_bus = r_lo;
        if (HIout)                 w_bus = r_hi;
        for (int i = 15; i >= 0; i--) begin
            if (w_rout[i]) w_bus = r_gpr[i];
        end
    end

    // Rotates done as a funnel shift of {Y,Y}; ROL by n equals ROR by (32-n) mod 32
    assign w_shamt = w_bus[4:0];
    assign w_rotr  = 32'({r_y, r_y} >> w_shamt);
    assign w_rotl  = 32'({r_y, r_y} >> (5'd0 - w_shamt));

    // Signed 64-bit product via explicit sign extension of both operands
    assign w_prod  = {{32{r_y[31]}}, r_y} * {{32{w_bus[31]}}, w_bus};

    // Signed divide; a zero divisor yields zero quotient and remainder
    always_comb begin
        w_quot = 32'd0;
        w_rem  = 32'd0;
        if (w_bus != 32'd0) begin
            w_quot = $signed(r_y) / $signed(w_bus);
            w_rem  = $signed(r_y) % $signed(w_bus);
        end
    end

    // ALU result selection; upper half is zero except for MUL/DIV
    always_comb begin
        w_alu = 64'd0;
        case (ALUSelection)
            c_OP_ADD:  w_alu[31:0] = r_y + w_bus;
            c_OP_SUB:  w_alu[31:0] = r_y - w_bus;
            c_OP_AND:  w_alu[31:0] = r_y & w_bus;
            c_OP_OR:   w_alu[31:0] = r_y | w_bus;
            c_OP_ROR:  w_alu[31:0] = w_rotr;
            c_OP_ROL:  w_alu[31:0] = w_rotl;
            c_OP_SHL:  w_alu[31:0] = r_y << w_shamt;
            c_OP_SHRA: w_alu[31:0] = $signed(r_y) >>> w_shamt;
            c_OP_SHR:  w_alu[31:0] = r_y >> w_shamt;
            c_OP_MUL:  w_alu       = w_prod;
            c_OP_DIV:  w_alu       = {w_rem, w_quot};
            c_OP_NEG:  w_alu[31:0] = 32'd0 - w_bus;
            c_OP_NOT:  w_alu[31:0] = ~w_bus;
            default:   w_alu       = 64'd0;
        endcase
    end

    // General register file: each Rn loads the bus when its enable is high
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_gpr <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_rin[i]) r_gpr[i] <= w_bus;
            end
        end
    end

    // Special registers; IncPC takes precedence over a PC load
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_pc  <= 32'd0;
            r_mdr <= 32'd0;
            r_mar <= 32'd0;
            r_ir  <= 32'd0;
            r_y   <= 32'd0;
            r_zhi <= 32'd0;
            r_zlo <= 32'd0;
        end else begin
            if (HIin)  r_hi  <= w_bus;
            if (Loin)  r_lo  <= w_bus;
            if (IncPC)     r_pc <= r_pc + 32'd1;
            else if (PCin) r_pc <= w_bus;
            if (MDRin) r_mdr <= MDRread ? Mdatain : w_bus;
            if (MARin) r_mar <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (Yin)   r_y   <= w_bus;
            if (Zin || ZHIin) r_zhi <= w_alu[63:32];
            if (Zin || ZLOin) r_zlo <= w_alu[31:0];
        end
    end

    assign R0  = r_gpr[0];
    assign R1  = r_gpr[1];
    assign R2  = r_gpr[2];
    assign R3  = r_gpr[3];
    assign R4  = r_gpr[4];
    assign R5  = r_gpr[5];
    assign R6  = r_gpr[6];
    assign R7  = r_gpr[7];
    assign R8  = r_gpr[8];
    assign R9  = r_gpr[9];
    assign R10 = r_gpr[10];
    assign R11 = r_gpr[11];
    assign R12 = r_gpr[12];
    assign R13 = r_gpr[13];
    assign R14 = r_gpr[14];
    assign R15 = r_gpr[15];

    assign HI         = r_hi;
    assign LO         = r_lo;
    assign Y          = r_y;
    assign ZHI        = r_zhi;
    assign ZLO        = r_zlo;
    assign PC         = r_pc;
    assign MDR        = r_mdr;
    assign MAR        = r_mar;
    assign IR         = r_ir;
    assign Z_register = {r_zhi, r_zlo};

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_datapath
// Description : Scoreboard bench for cpu_datapath. Expected register values
//               are queued as each control step is driven and compared one
//               clock later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_datapath;

    localparam int c_S_HI  = 16;
    localparam int c_S_LO  = 17;
    localparam int c_S_Y   = 18;
    localparam int c_S_ZHI = 19;
    localparam int c_S_ZLO = 20;
    localparam int c_S_Z   = 21;
    localparam int c_S_PC  = 22;
    localparam int c_S_MDR = 23;
    localparam int c_S_MAR = 24;
    localparam int c_S_IR  = 25;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] rin, rout;
    logic        HIin, Loin, PCin, MDRin, MARin, IRin, Yin, Zin, ZHIin, ZLOin;
    logic        HIout, Loout, PCout, MDRout, Yout, Cout, InPortout;
    logic        ZHIout, ZHighSelect, ZLOout, ZLowSelect, MDRread, IncPC;
    logic [4:0]  ALUSelection;
    logic [31:0] Mdatain;
    logic [15:0][31:0] rq;
    logic [31:0] HI, LO, Y, ZHI, ZLO, PC, MDR, MAR, IR;
    logic [63:0] Z_register;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } sb_t;
    sb_t sb_q[$];

    cpu_datapath dut (
        .clk(clk), .clr(clr),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIin(HIin), .Loin(Loin), .PCin(PCin), .MDRin(MDRin), .MARin(MARin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZHIin(ZHIin), .ZLOin(ZLOin),
        .HIout(HIout), .Loout(Loout), .PCout(PCout), .MDRout(MDRout), .Yout(Yout),
        .Cout(Cout), .InPortout(InPortout), .ZHIout(ZHIout), .ZHighSelect(ZHighSelect),
        .ZLOout(ZLOout), .ZLowSelect(ZLowSelect), .MDRread(MDRread), .IncPC(IncPC),
        .ALUSelection(ALUSelection), .Mdatain(Mdatain),
        .R0(rq[0]),   .R1(rq[1]),   .R2(rq[2]),   .R3(rq[3]),
        .R4(rq[4]),   .R5(rq[5]),   .R6(rq[6]),   .R7(rq[7]),
        .R8(rq[8]),   .R9(rq[9]),   .R10(rq[10]), .R11(rq[11]),
        .R12(rq[12]), .R13(rq[13]), .R14(rq[14]), .R15(rq[15]),
        .HI(HI), .LO(LO), .Y(Y), .ZHI(ZHI), .ZLO(ZLO),
        .PC(PC), .MDR(MDR), .MAR(MAR), .IR(IR), .Z_register(Z_register)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] get_out(input int sel);
        case (sel)
            c_S_HI:  return {32'd0, HI};
            c_S_LO:  return {32'd0, LO};
            c_S_Y:   return {32'd0, Y};
            c_S_ZHI: return {32'd0, ZHI};
            c_S_ZLO: return {32'd0, ZLO};
            c_S_Z:   return Z_register;
            c_S_PC:  return {32'd0, PC};
            c_S_MDR: return {32'd0, MDR};
            c_S_MAR: return {32'd0, MAR};
            c_S_IR:  return {32'd0, IR};
            default: return {32'd0, rq[sel]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [63:0] v);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, get_out(e.sel), e.exp);
        end
    endtask

    task automatic clear_ctrl();
        rin = '0; rout = '0;
        HIin = 0; Loin = 0; PCin = 0; MDRin = 0; MARin = 0; IRin = 0; Yin = 0;
        Zin = 0; ZHIin = 0; ZLOin = 0;
        HIout = 0; Loout = 0; PCout = 0; MDRout = 0; Yout = 0; Cout = 0; InPortout = 0;
        ZHIout = 0; ZHighSelect = 0; ZLOout = 0; ZLowSelect = 0;
        MDRread = 0; IncPC = 0; ALUSelection = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] val);
        Mdatain = val; MDRread = 1; MDRin = 1;
        tick();
        MDRout = 1; rin[idx] = 1;
        tick();
    endtask

    task automatic load_y(input int idx, input logic [31:0] val);
        load_reg(idx, val);
        rout[idx] = 1; Yin = 1;
        tick();
    endtask

    logic [4:0]  op_t [16] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                               5'b00111, 5'b01000, 5'b01001, 5'b01010,
                               5'b01011, 5'b01110, 5'b01111, 5'b00111,
                               5'b00000, 5'b10000, 5'b01100, 5'b01101};
    int          src_t [16] = '{13, 13, 13, 13, 13, 13, 13, 13,
                                13, 13, 13, 0,  13, 13, 13, 13};
    logic [63:0] ex_t [16] = '{64'h0000_0000_8000_0007, 64'h0000_0000_7FFF_FFFF,
                               64'h0000_0000_0000_0000, 64'h0000_0000_8000_0007,
                               64'h0000_0000_3800_0000, 64'h0000_0000_0000_0038,
                               64'h0000_0000_0000_0030, 64'h0000_0000_F800_0000,
                               64'h0000_0000_0800_0000, 64'h0000_0000_FFFF_FFFC,
                               64'h0000_0000_FFFF_FFFB, 64'h0000_0000_8000_0003,
                               64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000,
                               64'hFFFF_FFFE_0000_000C, 64'hFFFF_FFFF_E000_0001};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        clear_ctrl();
        Mdatain = 32'd0;
        clr = 1'b1;
        #1 clr = 1'b0;
        #1;
        for (int s = 0; s <= c_S_IR; s++) expect_out($sformatf("reset_sel%0d", s), s, 64'd0);
        drain();
        // loads held during reset must be ignored
        Mdatain = 32'h55; MDRread = 1; MDRin = 1; IncPC = 1;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_hold_mdr", c_S_MDR, 64'd0);
        expect_out("reset_hold_pc", c_S_PC, 64'd0);
        drain();
        clear_ctrl();
        #3 clr = 1'b1;

        // MDR from memory, then into R5
        Mdatain = 32'h0000_000A; MDRread = 1; MDRin = 1;
        expect_out("mdr_load", c_S_MDR, 64'h0A);
        tick(); drain();
        MDRout = 1; rin[5] = 1;
        expect_out("r5_load", 5, 64'h0A);
        tick(); drain();

        load_reg(3, 32'h2);
        load_reg(1, 32'h12);
        expect_out("r3_load", 3, 64'h2);
        expect_out("r1_load", 1, 64'h12);
        drain();
        rout[5] = 1; Yin = 1;
        expect_out("y_load", c_S_Y, 64'h0A);
        tick(); drain();
        rout[3] = 1; ALUSelection = 5'b01011; ZLOin = 1;
        expect_out("shr_zlo", c_S_ZLO, 64'h2);
        expect_out("shr_zhi_kept", c_S_ZHI, 64'h0);
        tick(); drain();
        ZLOout = 1; rin[1] = 1;
        expect_out("zlo_to_r1", 1, 64'h2);
        tick(); drain();
        ZLowSelect = 1; rin[15] = 1;
        expect_out("zlowsel_to_r15", 15, 64'h2);
        tick(); drain();

        // signed multiply
        load_y(6, 32'hFFFF_FFFE);
        load_reg(7, 32'h3);
        rout[7] = 1; ALUSelection = 5'b01100; Zin = 1;
        expect_out("mul_neg", c_S_Z, 64'hFFFF_FFFF_FFFF_FFFA);
        tick(); drain();

        // divide by zero, ZHI-only load, then full divide
        load_y(8, 32'h7);
        load_reg(9, 32'h0);
        rout[9] = 1; ALUSelection = 5'b01101; Zin = 1;
        expect_out("div_by_zero", c_S_Z, 64'h0);
        tick(); drain();
        load_reg(10, 32'h2);
        rout[10] = 1; ALUSelection = 5'b01101; ZHIin = 1;
        expect_out("div_zhi_only", c_S_Z, 64'h0000_0001_0000_0000);
        tick(); drain();
        rout[10] = 1; ALUSelection = 5'b01101; Zin = 1;
        expect_out("div_zlo", c_S_ZLO, 64'h3);
        expect_out("div_zhi", c_S_ZHI, 64'h1);
        tick(); drain();
        ZHighSelect = 1; rin[14] = 1;
        expect_out("zhisel_to_r14", 14, 64'h1);
        tick(); drain();

        // bus priority and idle bus
        load_reg(2, 32'h22);
        load_reg(4, 32'h44);
        rout[2] = 1; MDRout = 1; rin[11] = 1;
        expect_out("prio_r2_over_mdr", 11, 64'h22);
        tick(); drain();
        rin[4] = 1;
        expect_out("idle_bus_r4", 4, 64'h0);
        tick(); drain();

        // IR immediate sign extension and reserved in-port
        Mdatain = 32'hABC4_0001; MDRread = 1; MDRin = 1;
        tick();
        MDRout = 1; IRin = 1; MARin = 1;
        expect_out("ir_load", c_S_IR, 64'hABC4_0001);
        expect_out("mar_load", c_S_MAR, 64'hABC4_0001);
        tick(); drain();
        Cout = 1; HIin = 1;
        expect_out("c_sign_ext", c_S_HI, 64'hFFFC_0001);
        tick(); drain();
        Cout = 1; InPortout = 1; Loin = 1; rout[13] = 0;
        expect_out("inport_over_c", c_S_LO, 64'h0);
        tick(); drain();

        // ALU op table with Y=0x80000003, B=R13=4 (or R0=0 for the zero shift)
        load_y(12, 32'h8000_0003);
        load_reg(13, 32'h4);
        for (int i = 0; i < 16; i++) begin
            rout[src_t[i]] = 1; ALUSelection = op_t[i]; Zin = 1;
            expect_out($sformatf("alu_op%0d", i), c_S_Z, ex_t[i]);
            tick(); drain();
        end

        // asynchronous clear mid-cycle, IncPC held through it
        load_reg(1, 32'h12);
        Mdatain = 32'h5; MDRread = 1; MDRin = 1;
        tick();
        MDRout = 1; PCin = 1;
        expect_out("pc_load", c_S_PC, 64'h5);
        expect_out("r1_before_clr", 1, 64'h12);
        tick(); drain();
        #3 clr = 1'b0;
        #1;
        expect_out("clr_r1", 1, 64'h0);
        expect_out("clr_pc", c_S_PC, 64'h0);
        expect_out("clr_z", c_S_Z, 64'h0);
        expect_out("clr_y", c_S_Y, 64'h0);
        expect_out("clr_hi", c_S_HI, 64'h0);
        expect_out("clr_ir", c_S_IR, 64'h0);
        drain();
        IncPC = 1;
        @(posedge clk);
        #4 clr = 1'b1;
        @(posedge clk);
        #1;
        expect_out("incpc_after_clr", c_S_PC, 64'h1);
        drain();
        clear_ctrl();

        // IncPC overrides PCin
        Mdatain = 32'h100; MDRread = 1; MDRin = 1;
        tick();
        MDRout = 1; PCin = 1; IncPC = 1;
        expect_out("incpc_over_pcin", c_S_PC, 64'h2);
        tick(); drain();
        PCout = 1; rin[9] = 1;
        expect_out("pc_to_r9", 9, 64'h2);
        tick(); drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
